cpu_memory_responder: RTL and testbench



---
 rtl/cpu_memory_responder.sv | 106 ++++++++++
 tb/tb_cpu_memory_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_memory_responder.sv
// cpu_memory_responder: word-organised on-chip RAM serving the core's data interface
// Ports: CoreClock (posedge), Reset (sync, active-high), AddressBus (byte address, word access),
// DataWriteBus (store data), WriteAssert (store level, rising edge = request),
// DataReadBus/ReadOK (read data and valid for current address), WriteOK (one-cycle store ack).
// Optional macro MEMRESP_FAULT_EN adds AccessFault (sticky) and FaultAddress (first fault).
module cpu_memory_responder #(
    parameter int ADDR_WIDTH    = 10,
    parameter int READ_LATENCY  = 1,
    parameter int WRITE_LATENCY = 1
) (
    input  logic        CoreClock,
    input  logic        Reset,
    input  logic [31:0] AddressBus,
    input  logic [31:0] DataWriteBus,
    input  logic        WriteAssert,
    output logic [31:0] DataReadBus,
    output logic        ReadOK,
    output logic        WriteOK
`ifdef MEMRESP_FAULT_EN
    ,
    output logic        AccessFault,
    output logic [31:0] FaultAddress
`endif
);
    typedef enum logic [2:0] {IDLE, READ_WAIT, READ_VALID, WRITE_WAIT, WRITE_DONE} state_t;
    localparam logic [3:0] RD_LOAD = 4'(READ_LATENCY - 1);
    localparam logic [3:0] WR_LOAD = 4'(WRITE_LATENCY - 1);
    state_t state, state_nxt;
    logic [31:0] mem [2**ADDR_WIDTH];
    logic [31:0] latched_addr, wr_data;
    logic [3:0] cnt;
    logic write_prev, write_rise, reading, word_match, full_match, in_range, commit;
    logic [ADDR_WIDTH-1:0] idx;
    assign write_rise = WriteAssert & ~write_prev;
    assign reading    = state == IDLE || state == READ_WAIT || state == READ_VALID;
    assign word_match = AddressBus[31:2] == latched_addr[31:2];
    assign full_match = AddressBus == latched_addr;
    assign in_range   = latched_addr[31:ADDR_WIDTH+2] == '0;
    assign idx        = latched_addr[ADDR_WIDTH+1:2];
    assign commit     = state == WRITE_WAIT && cnt == '0;
    always_ff @(posedge CoreClock) begin
        if (Reset) state <= IDLE;
        else state <= state_nxt;
    end
    // A new store request pre-empts any read phase; the read restarts from IDLE afterwards.
    always_comb begin
        state_nxt = state;
        if (reading && write_rise) state_nxt = WRITE_WAIT;
        else case (state)
            IDLE:       state_nxt = READ_WAIT;
            READ_WAIT:  state_nxt = (full_match && cnt == '0) ? READ_VALID : READ_WAIT;
            READ_VALID: state_nxt = word_match ? READ_VALID : READ_WAIT;
            WRITE_WAIT: state_nxt = commit ? WRITE_DONE : WRITE_WAIT;
            default:    state_nxt = IDLE;
        endcase
    end
    // ReadOK is combinational so it drops in the very cycle the core moves the address.
    always_comb begin
        ReadOK  = state == READ_VALID && word_match;
        WriteOK = state == WRITE_DONE;
    end
    always_ff @(posedge CoreClock) begin
        if (Reset) begin
            cnt          <= '0;
            latched_addr <= '0;
            wr_data      <= '0;
            write_prev   <= 1'b0;
            DataReadBus  <= '0;
        end else begin
            write_prev <= WriteAssert;
            if (reading && write_rise) begin
                latched_addr <= AddressBus;
                wr_data      <= DataWriteBus;
                cnt          <= WR_LOAD;
            end else if (state == IDLE || (state == READ_WAIT && !full_match) ||
                         (state == READ_VALID && !word_match)) begin
                latched_addr <= AddressBus;
                cnt          <= RD_LOAD;
            end else if (state == READ_WAIT && cnt == '0) begin
                DataReadBus <= in_range ? mem[idx] : '0;
            end else if (cnt != '0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end
    // RAM is not reset; out-of-range stores are dropped but still acknowledged.
    always_ff @(posedge CoreClock) begin
        if (!Reset && commit && in_range) mem[idx] <= wr_data;
    end
`ifdef MEMRESP_FAULT_EN
    logic capture, fault_now;
    assign capture   = reading && (write_rise || state == IDLE || !word_match);
    assign fault_now = (capture && AddressBus[31:ADDR_WIDTH+2] != '0) ||
                       (AddressBus[1:0] != 2'b00 && (WriteAssert || state == READ_VALID)) ||
                       (write_rise && !reading);
    always_ff @(posedge CoreClock) begin
        if (Reset) begin
            AccessFault  <= 1'b0;
            FaultAddress <= '0;
        end else if (fault_now && !AccessFault) begin
            AccessFault  <= 1'b1;
            FaultAddress <= AddressBus;
        end
    end
`endif
endmodule

// File: tb/tb_cpu_memory_responder.sv
// tb_cpu_memory_responder: randomized self-checking bench for cpu_memory_responder
module tb_cpu_memory_responder;
    localparam int AW = 10;
    localparam int RL = 2;
    localparam int WL = 4;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst, we, rok, wok;
    logic [31:0] addr, wdata, rdata;
`ifdef MEMRESP_FAULT_EN
    logic fault;
    logic [31:0] faddr;
`endif
    int checks = 0;
    int fails = 0;
    logic [31:0] model [2**AW];

    cpu_memory_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(RL), .WRITE_LATENCY(WL)) dut (
        .CoreClock(clk),
        .Reset(rst),
        .AddressBus(addr),
        .DataWriteBus(wdata),
        .WriteAssert(we),
        .DataReadBus(rdata),
        .ReadOK(rok),
        .WriteOK(wok)
`ifdef MEMRESP_FAULT_EN
        ,
        .AccessFault(fault),
        .FaultAddress(faddr)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic in_range(input logic [31:0] a);
        return a[31:AW+2] == '0;
    endfunction

    function automatic logic [31:0] expect_read(input logic [31:0] a);
        return in_range(a) ? model[a[AW+1:2]] : 32'h0;
    endfunction

    // lat < 0 means the starting state is not controlled, so only the data is checked.
    task automatic do_read(input string name, input logic [31:0] a, input int lat);
        int n = 0;
        addr = a;
        #1;
        while (!rok && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (!rok || (lat >= 0 && n != lat)) begin
            fails++;
            $display("FAIL %s latency: ReadOK=%b after %0d edges, required 1 after %0d", name, rok, n, lat);
        end
        checks++;
        if (rdata !== expect_read(a)) begin
            fails++;
            $display("FAIL %s data @%h: got %h, required %h", name, a, rdata, expect_read(a));
        end
    endtask

    task automatic do_write(input string name, input logic [31:0] a, input logic [31:0] d, input int hold);
        int n = 0;
        addr = a;
        wdata = d;
        we = 1'b1;
        while (!wok && n < 50) begin
            tick();
            n++;
            if (n == 1) wdata = $urandom;
            if (n == hold) we = 1'b0;
        end
        we = 1'b0;
        if (in_range(a)) model[a[AW+1:2]] = d;
        checks++;
        if (!wok || n != WL + 1) begin
            fails++;
            $display("FAIL %s ack: WriteOK=%b after %0d edges, required 1 after %0d", name, wok, n, WL + 1);
        end
        tick();
        checks++;
        if (wok !== 1'b0) begin
            fails++;
            $display("FAIL %s pulse width: WriteOK=%b one cycle later, required 0", name, wok);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (rok !== 1'b0 || wok !== 1'b0 || rdata !== 32'h0) begin
            fails++;
            $display("FAIL %s outputs: ReadOK=%b WriteOK=%b DataReadBus=%h, required 0/0/0", name, rok, wok, rdata);
        end
`ifdef MEMRESP_FAULT_EN
        checks++;
        if (fault !== 1'b0 || faddr !== 32'h0) begin
            fails++;
            $display("FAIL %s fault outputs: %b/%h, required 0/0", name, fault, faddr);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        we = 1'b0;
        addr = 32'h0;
        wdata = 32'h0;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 1'b0;
    endtask

    task automatic test_write();
        do_write("write0", 32'h0, 32'h0000_0013, 1);
        do_write("write4", 32'h4, 32'hDEAD_BEEF, 1);
        do_write("write8", 32'h8, 32'hCAFE_F00D, 1);
    endtask

    task automatic test_read();
        do_read("read0", 32'h0, RL + 1);
        addr = 32'h4;
        #1;
        checks++;
        if (rok !== 1'b0) begin
            fails++;
            $display("FAIL addr_change drop: ReadOK=%b, required 0", rok);
        end
        do_read("read4", 32'h4, RL + 1);
        do_read("read8", 32'h8, RL + 1);
        do_read("read8_again", 32'h8, 0);
    endtask

    task automatic test_hold_high();
        int extra = 0;
        do_write("hold", 32'hC, 32'h1234_5678, 3);
        repeat (10) begin
            tick();
            if (wok) extra++;
        end
        checks++;
        if (extra != 0) begin
            fails++;
            $display("FAIL hold extra acks: got %0d, required 0", extra);
        end
`ifdef MEMRESP_FAULT_EN
        checks++;
        if (fault !== 1'b0) begin
            fails++;
            $display("FAIL hold fault: AccessFault=%b, required 0", fault);
        end
`endif
        do_read("hold_read", 32'hC, -1);
    endtask

    task automatic test_out_of_range();
        do_read("oor_read", 32'h0010_0000, RL + 1);
`ifdef MEMRESP_FAULT_EN
        checks++;
        if (fault !== 1'b1 || faddr !== 32'h0010_0000) begin
            fails++;
            $display("FAIL oor fault: %b/%h, required 1/00100000", fault, faddr);
        end
`endif
        do_write("oor_write", 32'h0010_0000, 32'h55AA_55AA, 1);
        do_read("oor_ram0", 32'h0, -1);
        do_read("oor_reread", 32'h0010_0000, -1);
    endtask

    task automatic test_write_priority();
        addr = 32'h10;
        tick();
        do_write("prio", 32'h14, $urandom, 1);
        do_read("prio_read", 32'h14, -1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) do_write("fill", 32'(i) << 2, $urandom, 1);
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a = 32'($urandom_range(0, 15)) << 2;
            if ($urandom_range(0, 2) == 0) do_write("rand_write", a, $urandom, int'($urandom_range(1, 3)));
            else do_read("rand_read", a, -1);
        end
    endtask

    task automatic test_reset_during_write();
        int acks = 0;
        addr = 32'h20;
        wdata = ~model[8];
        we = 1'b1;
        tick();
        tick();
        we = 1'b0;
        rst = 1'b1;
        tick();
        check_idle_outputs("rst_in_write");
        repeat (2) begin
            tick();
            if (wok) acks++;
        end
        rst = 1'b0;
        repeat (8) begin
            tick();
            if (wok) acks++;
        end
        checks++;
        if (acks != 0) begin
            fails++;
            $display("FAIL rst_in_write ack: got %0d WriteOK pulses, required 0", acks);
        end
        do_read("rst_in_write_read", 32'h20, -1);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_hold_high();
        test_out_of_range();
        test_write_priority();
        test_random();
        test_reset_during_write();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
